a_less_than_b_serial: RTL and testbench

A_LESS_THAN_B_SERIAL -- requirements
Module: a_less_than_b_serial

---
 rtl/a_less_than_b_serial.sv | 96 +++++++++
 tb/tb_a_less_than_b_serial.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/a_less_than_b_serial.sv
// Bit-serial unsigned magnitude comparator. Operands arrive MSB first; the first
// differing bit pair decides the result, which is published after WIDTH pairs.
module a_less_than_b_serial #(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic lt,
  output logic eq,
  output logic gt
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             decided;
  logic             prov_lt;
  logic             decided_nxt;
  logic             prov_lt_nxt;
  logic             last_pair;

  // MSB-first: the first unequal pair fixes the order, later pairs are don't-care.
  always_comb begin
    decided_nxt = decided;
    prov_lt_nxt = prov_lt;
    if (!decided && (a_bit != b_bit)) begin
      decided_nxt = 1'b1;
      prov_lt_nxt = b_bit;
    end
  end

  assign last_pair = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      decided <= 1'b0;
      prov_lt <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            cnt     <= '0;
            decided <= 1'b0;
            prov_lt <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        SHIFT: begin
          if (bit_valid) begin
            cnt     <= cnt + CNT_W'(1);
            decided <= decided_nxt;
            prov_lt <= prov_lt_nxt;
            if (last_pair) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              lt    <= decided_nxt & prov_lt_nxt;
              eq    <= ~decided_nxt;
              gt    <= decided_nxt & ~prov_lt_nxt;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_a_less_than_b_serial.sv
// Scoreboard bench for the serial comparator: stimulus pushes the expected
// ordering and done cycle, a negedge monitor pops and compares on each done.
module tb_a_less_than_b_serial;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic busy;
  logic done;
  logic lt;
  logic eq;
  logic gt;

  typedef struct {
    logic [2:0] res;
    int         done_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   gap_arr[W];

  a_less_than_b_serial #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bit_valid(bit_valid),
    .a_bit(a_bit), .b_bit(b_bit), .busy(busy), .done(done),
    .lt(lt), .eq(eq), .gt(gt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d results outstanding", sb.size());
    $fatal(1, "watchdog");
  end

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_done: done=1 at cycle %0d with no comparison pending", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({lt, eq, gt} !== e.res || cyc != e.done_cyc || busy !== 1'b0) begin
          errors++;
          $display("FAIL result: got lt/eq/gt=%b cycle=%0d busy=%b, expected lt/eq/gt=%b cycle=%0d busy=0",
                   {lt, eq, gt}, cyc, busy, e.res, e.done_cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  task automatic clear_gaps();
    for (int i = 0; i < W; i++) gap_arr[i] = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Issues start, then the W bit pairs MSB first with gap_arr[i] idle cycles before bit i.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
    int   total;
    exp_t e;
    total = 0;
    for (int i = 0; i < W; i++) total += gap_arr[i];
    start     = 1'b1;
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
    e.res      = {a < b, a == b, a > b};
    e.done_cyc = cyc + W + total;
    sb.push_back(e);
    check("busy_after_start", {7'd0, busy}, 8'd1);
    if (!hold) start = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      bit_valid = 1'b0;
      a_bit     = 1'($urandom);
      b_bit     = 1'($urandom);
      repeat (gap_arr[i]) begin
        @(posedge clk);
        #1;
      end
      bit_valid = 1'b1;
      a_bit     = a[i];
      b_bit     = b[i];
      @(posedge clk);
      #1;
    end
    bit_valid = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           hold;

    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    clear_gaps();
    idle(3);
    check("reset_state", {3'd0, busy, done, lt, eq, gt}, 8'd0);
    rst_n = 1'b1;
    idle(2);

    run_cmp(8'h35, 8'h36, 1'b0);
    idle(2);
    run_cmp(8'hA5, 8'hA5, 1'b0);
    idle(1);
    run_cmp(8'h80, 8'h7F, 1'b0);
    idle(2);
    gap_arr[3] = 3;
    run_cmp(8'h01, 8'h02, 1'b0);
    clear_gaps();
    idle(2);
    // start held through SHIFT, then reasserted in the DONE cycle.
    run_cmp(8'h00, 8'hFF, 1'b1);
    run_cmp(8'hFF, 8'h00, 1'b0);
    idle(2);
    check("result_held_in_idle", {5'd0, lt, eq, gt}, 8'b001);

    // Abort mid-stream: four pairs, then reset.
    start = 1'b1;
    idle(1);
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
      idle(1);
    end
    check("busy_before_abort", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_clears", {3'd0, busy, done, lt, eq, gt}, 8'd0);
    idle(2);
    check("reset_held", {3'd0, busy, done, lt, eq, gt}, 8'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("no_start_after_reset", {6'd0, busy, done}, 8'd0);
    end
    bit_valid = 1'b0;
    run_cmp(8'h10, 8'h10, 1'b0);
    idle(2);

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? ra : W'($urandom);
      for (int i = 0; i < W; i++)
        gap_arr[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      hold = ($urandom_range(0, 7) == 0);
      run_cmp(ra, rb, hold);
      idle(int'($urandom_range(0, 2)));
    end
    clear_gaps();

    idle(3);
    check("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
